// File: rtl/dca_matrix_lsu_inst_arbiter_if.sv
// ============================================================================
// Module      : dca_matrix_lsu_inst_arbiter_if
// Description : Requester-side and LSU-side instruction bus of the LSU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dca_matrix_lsu_inst_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int BW_INST = 32
);
    logic [NUM_REQ-1:0]         req_wvalid;
    logic [NUM_REQ*BW_INST-1:0] req_wdata;
    logic [NUM_REQ-1:0]         req_wready;
    logic [NUM_REQ-1:0]         req_decode_finish;
    logic [NUM_REQ-1:0]         req_execute_finish;
    logic                       lsu_inst_wvalid;
    logic [BW_INST-1:0]         lsu_inst_wdata;
    logic                       lsu_inst_wready;
    logic                       lsu_inst_decode_finish;
    logic                       lsu_inst_execute_finish;

    // Drives requests and LSU responses (requesters plus LSU model)
    modport master (
        output req_wvalid, req_wdata,
        output lsu_inst_wready, lsu_inst_decode_finish, lsu_inst_execute_finish,
        input  req_wready, req_decode_finish, req_execute_finish,
        input  lsu_inst_wvalid, lsu_inst_wdata
    );

    // The arbiter itself
    modport slave (
        input  req_wvalid, req_wdata,
        input  lsu_inst_wready, lsu_inst_decode_finish, lsu_inst_execute_finish,
        output req_wready, req_decode_finish, req_execute_finish,
        output lsu_inst_wvalid, lsu_inst_wdata
    );
endinterface

`default_nettype wire

// File: rtl/dca_matrix_lsu_inst_arbiter.sv
// ============================================================================
// Module      : dca_matrix_lsu_inst_arbiter
// Description : Round-robin share of one matrix LSU instruction port, with
//               in-order routing of decode/execute finish pulses to requesters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dca_matrix_lsu_inst_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int BW_INST         = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire                              clk,
    input  wire                              rstnn,
    input  wire                              clear_i,
    input  wire                              enable_i,
    dca_matrix_lsu_inst_arbiter_if.slave     bus,
    output logic                             busy_o,
    output logic                             protocol_error_o
);
    localparam int BW_ID   = $clog2(NUM_REQ);
    localparam int BW_OUT  = $clog2(MAX_OUTSTANDING + 1);
    localparam int BW_PTR  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int BW_ADDR = BW_PTR - 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [0:0]         state_q, state_d;
    logic [BW_ID-1:0]   grant_q, grant_d;
    logic [BW_ID-1:0]   rr_ptr_q, rr_ptr_d;
    logic [BW_OUT-1:0]  outstanding_q;
    logic               perr_q;
    logic [BW_PTR-1:0]  dq_wr_q, dq_rd_q, eq_wr_q, eq_rd_q;
    logic [BW_ID-1:0]   dq_mem_q [MAX_OUTSTANDING];
    logic [BW_ID-1:0]   eq_mem_q [MAX_OUTSTANDING];

    logic [BW_ID-1:0]   w_arb_idx;
    logic [BW_INST-1:0] w_grant_data;
    logic               w_lsu_wvalid;
    logic               w_accept;
    logic               w_full;
    logic               w_dq_empty, w_eq_empty;
    logic               w_dq_pop, w_eq_pop;
    logic [BW_ID-1:0]   w_dq_head, w_eq_head;

    // First valid requester at or after the round-robin pointer
    always_comb begin
        int cand;
        logic found;
        cand      = 0;
        found     = 1'b0;
        w_arb_idx = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && bus.req_wvalid[BW_ID'(cand)]) begin
                found     = 1'b1;
                w_arb_idx = BW_ID'(cand);
            end
        end
    end

    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == BW_ID'(i)) begin
                w_grant_data = bus.req_wdata[i*BW_INST +: BW_INST];
            end
        end
    end

    assign w_full = (outstanding_q == BW_OUT'(MAX_OUTSTANDING));

    // FSM: state register
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else if (clear_i) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // FSM: next state; enable_i=0 freezes everything (w_accept is already gated)
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i && (|bus.req_wvalid) && !w_full) begin
                    grant_d = w_arb_idx;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_accept) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (grant_q == BW_ID'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                end else if (enable_i && !bus.req_wvalid[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_lsu_wvalid       = (state_q == S_ISSUE) && enable_i && bus.req_wvalid[grant_q];
        w_accept           = w_lsu_wvalid && bus.lsu_inst_wready;
        bus.lsu_inst_wvalid = w_lsu_wvalid;
        bus.lsu_inst_wdata  = (state_q == S_ISSUE) ? w_grant_data : '0;
        bus.req_wready      = w_accept ? (ONE_HOT0 << grant_q) : '0;
    end

    // Id tracking queues: decode queue feeds execute queue, no bypass
    assign w_dq_empty = (dq_wr_q == dq_rd_q);
    assign w_eq_empty = (eq_wr_q == eq_rd_q);
    assign w_dq_head  = dq_mem_q[dq_rd_q[BW_ADDR-1:0]];
    assign w_eq_head  = eq_mem_q[eq_rd_q[BW_ADDR-1:0]];
    assign w_dq_pop   = bus.lsu_inst_decode_finish  && !w_dq_empty;
    assign w_eq_pop   = bus.lsu_inst_execute_finish && !w_eq_empty;

    assign bus.req_decode_finish  = w_dq_pop ? (ONE_HOT0 << w_dq_head) : '0;
    assign bus.req_execute_finish = w_eq_pop ? (ONE_HOT0 << w_eq_head) : '0;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            dq_mem_q[dq_wr_q[BW_ADDR-1:0]] <= grant_q;
        end
        if (w_dq_pop) begin
            eq_mem_q[eq_wr_q[BW_ADDR-1:0]] <= w_dq_head;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            dq_wr_q       <= '0;
            dq_rd_q       <= '0;
            eq_wr_q       <= '0;
            eq_rd_q       <= '0;
            outstanding_q <= '0;
            perr_q        <= 1'b0;
        end else if (clear_i) begin
            dq_wr_q       <= '0;
            dq_rd_q       <= '0;
            eq_wr_q       <= '0;
            eq_rd_q       <= '0;
            outstanding_q <= '0;
            perr_q        <= 1'b0;
        end else begin
            dq_wr_q       <= dq_wr_q + BW_PTR'(w_accept);
            dq_rd_q       <= dq_rd_q + BW_PTR'(w_dq_pop);
            eq_wr_q       <= eq_wr_q + BW_PTR'(w_dq_pop);
            eq_rd_q       <= eq_rd_q + BW_PTR'(w_eq_pop);
            outstanding_q <= outstanding_q + BW_OUT'(w_accept) - BW_OUT'(w_eq_pop);
            if ((bus.lsu_inst_decode_finish && w_dq_empty) ||
                (bus.lsu_inst_execute_finish && w_eq_empty)) begin
                perr_q <= 1'b1;
            end
        end
    end

    assign busy_o           = (state_q != S_IDLE) || (outstanding_q != '0) || (|bus.req_wvalid);
    assign protocol_error_o = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_dca_matrix_lsu_inst_arbiter.sv
// ============================================================================
// Module      : tb_dca_matrix_lsu_inst_arbiter
// Description : Directed and random bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dca_matrix_lsu_inst_arbiter;
    localparam int N    = 2;
    localparam int BW   = 32;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic rstnn, clear, enable;
    logic busy, perr;

    always #5 clk = ~clk;

    dca_matrix_lsu_inst_arbiter_if #(.NUM_REQ(N), .BW_INST(BW)) bus ();

    dca_matrix_lsu_inst_arbiter #(
        .NUM_REQ(N), .BW_INST(BW), .MAX_OUTSTANDING(MAXO)
    ) u_dut (
        .clk              (clk),
        .rstnn            (rstnn),
        .clear_i          (clear),
        .enable_i         (enable),
        .bus              (bus),
        .busy_o           (busy),
        .protocol_error_o (perr)
    );

    // Reference model: pending-grant flag, round-robin pointer, id queues
    bit     m_issue;
    int     m_grant, m_rr, m_out;
    bit     m_err;
    int     dq[$];
    int     eq[$];
    bit     s_acc, s_decv, s_exev;
    logic [N-1:0] s_wr;

    int n_checks = 0;
    int n_errors = 0;

    logic [N-1:0]  pend;
    logic [BW-1:0] pdat [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_issue = 0; m_grant = 0; m_rr = 0; m_out = 0; m_err = 0;
        dq.delete(); eq.delete();
    endtask

    task automatic check_now();
        logic          e_v;
        logic [BW-1:0] e_wd;
        logic [N-1:0]  e_dec, e_exe;
        #1;
        e_v    = m_issue && enable && bus.req_wvalid[m_grant];
        e_wd   = m_issue ? bus.req_wdata[m_grant*BW +: BW] : '0;
        s_acc  = e_v && bus.lsu_inst_wready;
        s_wr   = s_acc ? (N'(1) << m_grant) : '0;
        s_decv = bus.lsu_inst_decode_finish && (dq.size() > 0);
        s_exev = bus.lsu_inst_execute_finish && (eq.size() > 0);
        e_dec  = s_decv ? (N'(1) << dq[0]) : '0;
        e_exe  = s_exev ? (N'(1) << eq[0]) : '0;
        chk("lsu_wvalid", bus.lsu_inst_wvalid, e_v);
        chk("lsu_wdata", bus.lsu_inst_wdata, e_wd);
        chk("req_wready", bus.req_wready, s_wr);
        chk("req_dec_fin", bus.req_decode_finish, e_dec);
        chk("req_exe_fin", bus.req_execute_finish, e_exe);
        chk("busy", busy, m_issue || (m_out != 0) || (|bus.req_wvalid));
        chk("perr", perr, m_err);
    endtask

    task automatic model_update();
        int old_out;
        if (!rstnn || clear) begin
            model_reset();
            return;
        end
        old_out = m_out;
        if (bus.lsu_inst_decode_finish && !s_decv) m_err = 1;
        if (bus.lsu_inst_execute_finish && !s_exev) m_err = 1;
        if (s_exev) void'(eq.pop_front());
        if (s_decv) eq.push_back(dq.pop_front());
        if (s_acc) dq.push_back(m_grant);
        m_out = m_out + int'(s_acc) - int'(s_exev);
        if (enable) begin
            if (!m_issue) begin
                if ((|bus.req_wvalid) && old_out < MAXO) begin
                    for (int k = 0; k < N; k++) begin
                        if (bus.req_wvalid[(m_rr + k) % N]) begin
                            m_grant = (m_rr + k) % N;
                            break;
                        end
                    end
                    m_issue = 1;
                end
            end else if (s_acc) begin
                m_issue = 0;
                m_rr    = (m_grant + 1) % N;
            end else if (!bus.req_wvalid[m_grant]) begin
                m_issue = 0;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        check_now();
        advance();
    endtask

    task automatic set_idle();
        bus.req_wvalid = '0;
        bus.lsu_inst_wready = 1'b0;
        bus.lsu_inst_decode_finish = 1'b0;
        bus.lsu_inst_execute_finish = 1'b0;
        clear = 1'b0;
        enable = 1'b1;
    endtask

    task automatic do_clear();
        set_idle();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic issue_one(input int id);
        bit got = 0;
        bus.req_wvalid = N'(1) << id;
        bus.lsu_inst_wready = 1'b1;
        for (int t = 0; t < 10 && !got; t++) begin
            check_now();
            got = s_acc;
            advance();
        end
        chk("issue_timeout", got, 1'b1);
        bus.req_wvalid = '0;
        bus.lsu_inst_wready = 1'b0;
    endtask

    initial begin
        int n_acc;
        int last;
        logic [N-1:0] seq [3];

        rstnn = 1'b0;
        bus.req_wdata = '0;
        set_idle();
        model_reset();
        #1;
        chk("rst_wvalid", bus.lsu_inst_wvalid, 1'b0);
        chk("rst_wdata", bus.lsu_inst_wdata, '0);
        chk("rst_wready", bus.req_wready, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_perr", perr, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rstnn = 1'b1;

        // 1: single requester, LSU ready after two cycles
        bus.req_wdata[0 +: BW] = 32'hA5A5_0001;
        bus.req_wvalid = 2'b01;
        step();
        step();
        check_now();
        chk("t1_wdata", bus.lsu_inst_wdata, 32'hA5A5_0001);
        advance();
        bus.lsu_inst_wready = 1'b1;
        check_now();
        chk("t1_wready", bus.req_wready, 2'b01);
        advance();
        set_idle();
        step();
        bus.lsu_inst_decode_finish = 1'b1;
        check_now();
        chk("t1_dec", bus.req_decode_finish, 2'b01);
        advance();
        bus.lsu_inst_decode_finish = 1'b0;
        bus.lsu_inst_execute_finish = 1'b1;
        check_now();
        chk("t1_exe", bus.req_execute_finish, 2'b01);
        advance();
        set_idle();

        // 2: both requesters always valid, LSU always ready and finishing
        do_clear();
        bus.req_wdata = {32'h1111_1111, 32'h0000_0000};
        bus.req_wvalid = 2'b11;
        bus.lsu_inst_wready = 1'b1;
        last = -1;
        for (int c = 0; c < 12; c++) begin
            bus.lsu_inst_decode_finish = (dq.size() > 0);
            bus.lsu_inst_execute_finish = (eq.size() > 0);
            check_now();
            if (|bus.req_wready) begin
                if (last >= 0) chk("t2_alternate", int'(bus.req_wready[1]) != last, 1'b1);
                last = int'(bus.req_wready[1]);
            end
            advance();
        end
        set_idle();

        // 3: LSU never finishes -> accepts stop at MAX_OUTSTANDING
        do_clear();
        bus.req_wvalid = 2'b01;
        bus.lsu_inst_wready = 1'b1;
        n_acc = 0;
        for (int c = 0; c < 14; c++) begin
            check_now();
            if (bus.req_wready[0]) n_acc++;
            advance();
        end
        chk("t3_acc_cap", n_acc, MAXO);
        #1;
        chk("t3_busy", busy, 1'b1);
        @(negedge clk);
        bus.lsu_inst_decode_finish = 1'b1;
        step();
        bus.lsu_inst_decode_finish = 1'b0;
        bus.lsu_inst_execute_finish = 1'b1;
        step();
        bus.lsu_inst_execute_finish = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_now();
            if (bus.req_wready[0]) n_acc++;
            advance();
        end
        chk("t3_fifth", n_acc, MAXO + 1);
        set_idle();

        // 4: ids 1,0,1 routed back in order
        do_clear();
        issue_one(1);
        issue_one(0);
        issue_one(1);
        bus.lsu_inst_decode_finish = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_now();
            seq[c] = bus.req_decode_finish;
            advance();
        end
        chk("t4_dec0", seq[0], 2'b10);
        chk("t4_dec1", seq[1], 2'b01);
        chk("t4_dec2", seq[2], 2'b10);
        bus.lsu_inst_decode_finish = 1'b0;
        bus.lsu_inst_execute_finish = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check_now();
            seq[c] = bus.req_execute_finish;
            advance();
        end
        chk("t4_exe0", seq[0], 2'b10);
        chk("t4_exe1", seq[1], 2'b01);
        chk("t4_exe2", seq[2], 2'b10);
        bus.lsu_inst_execute_finish = 1'b0;
        // accept, decode and execute in one cycle
        issue_one(0);
        issue_one(1);
        bus.lsu_inst_decode_finish = 1'b1;
        step();
        bus.lsu_inst_decode_finish = 1'b0;
        bus.req_wvalid = 2'b01;
        bus.lsu_inst_wready = 1'b1;
        step();
        bus.lsu_inst_decode_finish = 1'b1;
        bus.lsu_inst_execute_finish = 1'b1;
        check_now();
        chk("t4_sim_wr", bus.req_wready, 2'b01);
        chk("t4_sim_dec", bus.req_decode_finish, 2'b10);
        chk("t4_sim_exe", bus.req_execute_finish, 2'b01);
        advance();
        set_idle();
        bus.lsu_inst_decode_finish = 1'b1;
        bus.lsu_inst_execute_finish = 1'b1;
        step();
        step();
        bus.lsu_inst_decode_finish = 1'b0;
        step();
        set_idle();
        step();

        // 5: execute finish with empty queue
        bus.lsu_inst_execute_finish = 1'b1;
        check_now();
        chk("t5_nopulse", bus.req_execute_finish, '0);
        advance();
        set_idle();
        #1;
        chk("t5_perr", perr, 1'b1);
        @(negedge clk);
        do_clear();
        #1;
        chk("t5_clr_perr", perr, 1'b0);
        chk("t5_clr_busy", busy, 1'b0);
        @(negedge clk);

        // 6: async reset while issuing with two outstanding
        issue_one(0);
        issue_one(1);
        bus.req_wvalid = 2'b01;
        step();
        step();
        #2;
        rstnn = 1'b0;
        bus.req_wvalid = '0;
        #1;
        chk("t6_wvalid", bus.lsu_inst_wvalid, 1'b0);
        chk("t6_wdata", bus.lsu_inst_wdata, '0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_perr", perr, 1'b0);
        model_reset();
        @(negedge clk);
        rstnn = 1'b1;
        step();
        bus.lsu_inst_decode_finish = 1'b1;
        step();
        set_idle();
        step();
        do_clear();

        // Random traffic: requesters hold until accepted
        pend = '0;
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    pdat[i] = $urandom;
                end
                bus.req_wvalid[i] = pend[i];
                bus.req_wdata[i*BW +: BW] = pdat[i];
            end
            bus.lsu_inst_wready = 1'($urandom_range(0, 1));
            bus.lsu_inst_decode_finish = (dq.size() > 0) && ($urandom_range(0, 2) == 0);
            bus.lsu_inst_execute_finish = (eq.size() > 0) && ($urandom_range(0, 2) == 0);
            enable = ($urandom_range(0, 7) != 0);
            check_now();
            pend = pend & ~s_wr;
            advance();
        end
        set_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule

`default_nettype wire
